// File: rtl/ds_decimator_if.sv
// Port bundle for ds_decimator: modulator bit input, decimated sample output
// and overrun status. slave is the decimator's view, master the producer/consumer side.
interface ds_decimator_if;
  logic        bit_in;
  logic        bit_valid;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;
  logic        clr_ovr;

  modport master (
    output bit_in, bit_valid, dout_ready, clr_ovr,
    input  dout, dout_valid, overrun
  );

  modport slave (
    input  bit_in, bit_valid, dout_ready, clr_ovr,
    output dout, dout_valid, overrun
  );
endinterface

// File: rtl/ds_decimator.sv
// Delta-sigma bitstream decimator: sinc1 integrate-and-dump by default, order-2 CIC
// when DS_DECIM_SINC2_EN is defined. One saturated 16-bit sample per OSR accepted bits.
module ds_decimator #(
  parameter int OSR = 256
) (
  input logic           clk,
  input logic           rst_n,
  ds_decimator_if.slave bus
);

  localparam int LW = $clog2(OSR);
  localparam int SW = 48;
  localparam logic signed [SW-1:0] MAX_S = SW'(32767);
  localparam logic signed [SW-1:0] MIN_S = -SW'(32768);

  function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] v);
    if (v > MAX_S)      sat16 = 16'sh7fff;
    else if (v < MIN_S) sat16 = 16'sh8000;
    else                sat16 = v[15:0];
  endfunction

  logic [LW-1:0]      cnt;
  logic               frame_end;
  logic               frame_ok;
  logic signed [15:0] frame_sample;
  logic               res_vld;
  logic signed [15:0] res_q;
  logic [15:0]        dout_q;
  logic               dout_valid_q;
  logic               overrun_q;

  assign frame_end = bus.bit_valid && (cnt == LW'(OSR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (bus.bit_valid) cnt <= cnt + LW'(1);
  end

`ifdef DS_DECIM_SINC2_EN
  localparam int IW = 2 * LW + 2;

  logic signed [IW-1:0] int1, int2, int1_nx, int2_nx;
  logic signed [IW-1:0] x_prev, c1_prev, c1, c2, scaled;
  logic signed [IW-1:0] step;
  logic                 primed;

  // {~b...~b,1} is +1 for a one and -1 for a zero
  assign step    = {{(IW-1){~bus.bit_in}}, 1'b1};
  assign int1_nx = int1 + step;
  assign int2_nx = int2 + int1_nx;
  assign c1      = int2_nx - x_prev;
  assign c2      = c1 - c1_prev;
  assign scaled  = c2 >>> LW;

  assign frame_sample = sat16({{(SW-IW){scaled[IW-1]}}, scaled});
  // The first frame only primes the comb history
  assign frame_ok     = frame_end && primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1    <= '0;
      int2    <= '0;
      x_prev  <= '0;
      c1_prev <= '0;
      primed  <= 1'b0;
    end else if (bus.bit_valid) begin
      int1 <= int1_nx;
      int2 <= int2_nx;
      if (frame_end) begin
        x_prev  <= int2_nx;
        c1_prev <= c1;
        primed  <= 1'b1;
      end
    end
  end
`else
  localparam int AW = LW + 2;

  logic signed [AW-1:0] acc, acc_nx, step;

  assign step   = {{(AW-1){~bus.bit_in}}, 1'b1};
  assign acc_nx = acc + step;

  // The frame's last bit is folded into this frame's result
  assign frame_sample = sat16({{(SW-AW){acc_nx[AW-1]}}, acc_nx});
  assign frame_ok     = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             acc <= '0;
    else if (bus.bit_valid) acc <= frame_end ? '0 : acc_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld <= 1'b0;
      res_q   <= '0;
    end else begin
      res_vld <= frame_ok;
      if (frame_ok) res_q <= frame_sample;
    end
  end

  // Output handshake: a sample transfers on a rising edge with dout_valid && dout_ready;
  // dout_valid never waits on dout_ready, and a new sample landing on an untaken one sets overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (res_vld) begin
        dout_q       <= res_q;
        dout_valid_q <= 1'b1;
      end else if (dout_valid_q && bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end
      if (res_vld && dout_valid_q && !bus.dout_ready) overrun_q <= 1'b1;
      else if (bus.clr_ovr)                           overrun_q <= 1'b0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ds_decimator.sv
// Self-checking bench for ds_decimator at OSR=16; reference is a sliding-window
// (boxcar or triangular) sum over the accepted-bit history.
module tb_ds_decimator;

  localparam int OSR = 16;
  localparam int LW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ds_decimator_if bus ();

  ds_decimator #(.OSR(OSR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  int          hist[$];
  int          bit_cnt = 0;
  int          frame_no = 0;
  bit          keep_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_result();
    longint y = 0;
    int     h;
    int     idx;
`ifdef DS_DECIM_SINC2_EN
    for (int m = 0; m <= 2 * OSR - 2; m++) begin
      h   = (m < OSR) ? m + 1 : 2 * OSR - 1 - m;
      idx = hist.size() - 1 - m;
      if (idx >= 0) y += longint'(h * hist[idx]);
    end
    y = y >>> LW;
`else
    for (int m = 0; m < OSR; m++) begin
      idx = hist.size() - 1 - m;
      if (idx >= 0) y += longint'(hist[idx]);
    end
`endif
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y[15:0];
  endfunction

  task automatic drive_bit(input logic b, input logic v);
    bus.bit_in    = b;
    bus.bit_valid = v;
    @(posedge clk);
    if (v) begin
      hist.push_back(b ? 1 : -1);
      if (hist.size() > 2 * OSR) void'(hist.pop_front());
      bit_cnt++;
      if (bit_cnt == OSR) begin
        bit_cnt = 0;
        frame_no++;
`ifdef DS_DECIM_SINC2_EN
        if (frame_no > 1) begin
`else
        begin
`endif
          if (keep_last) exp_q.delete();
          exp_q.push_back(model_result());
        end
      end
    end
    #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b0, 1'b0);
  endtask

  task automatic send_const(input logic b, input int n);
    repeat (n) drive_bit(b, 1'b1);
  endtask

  task automatic clear_model();
    hist.delete();
    exp_q.delete();
    bit_cnt  = 0;
    frame_no = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, bus.dout, 32'd0);
    check({tag, "_valid"}, bus.dout_valid, 32'd0);
    check({tag, "_ovr"}, bus.overrun, 32'd0);
  endtask

  task automatic random_frames(input int frames);
    int accepted = 0;
    logic v;
    while (accepted < frames * OSR) begin
      v = ($urandom_range(0, 3) != 0);
      drive_bit(1'($urandom_range(0, 1)), v);
      if (v) accepted++;
    end
    idle(3);
  endtask

  // Scoreboard: every accepted output sample is compared against the queue head
  always @(negedge clk) begin
    if (rst_n && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   check("dout", bus.dout, exp_q.pop_front());
    end
  end

  initial begin
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    bus.clr_ovr    = 1'b0;
    rst_n          = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef DS_DECIM_SINC2_EN
    send_const(1'b1, OSR);
    idle(2);
    check("s2_no_first", bus.dout_valid, 32'd0);
    send_const(1'b1, 2 * OSR);
    idle(2);
    check("s2_ones_dout", bus.dout, 32'h0010);
    send_const(1'b0, 3 * OSR);
    idle(2);
    check("s2_zeros_dout", bus.dout, 32'hfff0);
    random_frames(4);
`else
    // Single frame of ones: registered result one cycle after the last bit
    send_const(1'b1, OSR);
    check("t1_valid_lo", bus.dout_valid, 32'd0);
    idle(1);
    check("t1_valid_hi", bus.dout_valid, 32'd1);
    check("t1_dout", bus.dout, 32'h0010);
    idle(1);
    check("t1_valid_drop", bus.dout_valid, 32'd0);

    send_const(1'b0, OSR);
    for (int i = 0; i < OSR; i++) drive_bit(1'(i % 2 == 0), 1'b1);
    idle(2);
    check("t2_last", bus.dout, 32'h0000);

    // Overrun with the consumer stalled
    bus.dout_ready = 1'b0;
    keep_last = 1'b1;
    send_const(1'b1, 2 * OSR);
    idle(1);
    check("t3_ovr_set", bus.overrun, 32'd1);
    check("t3_dout", bus.dout, 32'h0010);
    check("t3_valid", bus.dout_valid, 32'd1);
    bus.clr_ovr = 1'b1;
    idle(1);
    bus.clr_ovr = 1'b0;
    check("t3_ovr_clr", bus.overrun, 32'd0);
    send_const(1'b1, OSR);
    bus.clr_ovr = 1'b1;
    idle(1);
    bus.clr_ovr = 1'b0;
    check("t3_set_wins", bus.overrun, 32'd1);
    keep_last = 1'b0;
    bus.dout_ready = 1'b1;
    bus.clr_ovr = 1'b1;
    idle(2);
    bus.clr_ovr = 1'b0;
    check("t3_ovr_final", bus.overrun, 32'd0);

    // Reset in the middle of a frame discards the partial frame
    send_const(1'b1, 7);
    rst_n = 1'b0;
    clear_model();
    #2;
    check_outputs_zero("t4_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_const(1'b1, OSR);
    idle(1);
    check("t4_dout", bus.dout, 32'h0010);
    idle(1);

    // Counter advances only on accepted bits
    for (int i = 0; i < OSR; i++) begin
      drive_bit(1'b1, 1'b1);
      if (i != OSR - 1) begin
        check("t5_no_early", bus.dout_valid, 32'd0);
        drive_bit(1'b1, 1'b0);
      end
    end
    idle(1);
    check("t5_valid", bus.dout_valid, 32'd1);
    idle(1);

    random_frames(4);
`endif

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
